// File: rtl/spi_pkg.sv
// Shared types and default sizing for the SPI receive datapath.
package spi_pkg;

    typedef enum logic [1:0] {IDLE, RECV, CAPTURE, WAIT_END} spi_rx_state_t;

    localparam int SPI_DATA_WIDTH     = 16;
    localparam int SPI_DATA_QUANTITY  = 2;
    localparam int SPI_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/spi_rx_timeout.sv
// Saturating stall counter; expired flags the last idle cycle before abort.
module spi_rx_timeout #(
    parameter int CYCLES = 1024
) (
    input  logic clk,
    input  logic nrst,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int TW = $clog2(CYCLES + 1);

    logic [TW-1:0] timer_reg;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            timer_reg <= '0;
        end else if (clear) begin
            timer_reg <= '0;
        end else if (inc && (timer_reg != TW'(CYCLES))) begin
            timer_reg <= timer_reg + 1'b1;
        end
    end

    assign expired = (timer_reg == TW'(CYCLES - 1));

endmodule

// File: rtl/spi_rx_ctrl.sv
// SPI receive frame sequencer: gates shifting, captures the finished word
// and hands it downstream on valid/ready, flagging short/stalled/overrun frames.
module spi_rx_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH     = SPI_DATA_WIDTH,
    parameter int DATA_QUANTITY  = SPI_DATA_QUANTITY,
    parameter int TIMEOUT_CYCLES = SPI_TIMEOUT_CYCLES
) (
    input  logic                              clk,
    input  logic                              nrst,
    input  logic                              cs_rise,
    input  logic                              cs_fall,
    input  logic                              bit_strobe,
    input  logic [DATA_WIDTH*DATA_QUANTITY-1:0] rx_data,
    input  logic                              out_ready,
    output logic                              shift_en,
    output logic                              busy,
    output logic                              out_valid,
    output logic [DATA_WIDTH*DATA_QUANTITY-1:0] out_data,
    output logic                              err_short,
    output logic                              err_timeout,
    output logic                              err_overrun
);

    localparam int W  = DATA_WIDTH * DATA_QUANTITY;
    localparam int CW = $clog2(DATA_WIDTH + 1);

    spi_rx_state_t state_reg, state_next;
    logic [CW-1:0] bit_cnt_reg;
    logic          end_seen_reg, end_seen_next;
    logic          out_valid_reg;
    logic [W-1:0]  out_data_reg;
    logic          err_short_reg, err_timeout_reg, err_overrun_reg;
    logic          short_next, timeout_next, overrun_next;
    logic          cnt_clear, cnt_inc, tmr_clear, tmr_inc, tmr_expired, capture;

    spi_rx_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .nrst    (nrst),
        .clear   (tmr_clear),
        .inc     (tmr_inc),
        .expired (tmr_expired)
    );

    always_comb begin
        state_next    = state_reg;
        end_seen_next = end_seen_reg;
        cnt_clear     = 1'b0;
        cnt_inc       = 1'b0;
        tmr_clear     = 1'b0;
        tmr_inc       = 1'b0;
        capture       = 1'b0;
        short_next    = 1'b0;
        timeout_next  = 1'b0;
        overrun_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cs_rise) begin
                    state_next = RECV;
                    cnt_clear  = 1'b1;
                    tmr_clear  = 1'b1;
                end
            end
            RECV: begin
                // Completing strobe beats a restart, which beats end/abort.
                if (bit_strobe && (bit_cnt_reg == CW'(DATA_WIDTH - 1))) begin
                    state_next    = CAPTURE;
                    end_seen_next = cs_fall;
                    cnt_inc       = 1'b1;
                    tmr_clear     = 1'b1;
                end else if (cs_rise) begin
                    cnt_clear = 1'b1;
                    tmr_clear = 1'b1;
                end else if (cs_fall) begin
                    short_next = 1'b1;
                    state_next = IDLE;
                end else if (bit_strobe) begin
                    cnt_inc   = 1'b1;
                    tmr_clear = 1'b1;
                end else if (tmr_expired) begin
                    timeout_next = 1'b1;
                    state_next   = IDLE;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            CAPTURE: begin
                capture      = 1'b1;
                overrun_next = out_valid_reg && !out_ready;
                if (cs_rise) begin
                    state_next = RECV;
                    cnt_clear  = 1'b1;
                    tmr_clear  = 1'b1;
                end else if (end_seen_reg || cs_fall) begin
                    state_next = IDLE;
                end else begin
                    state_next = WAIT_END;
                end
            end
            WAIT_END: begin
                if (cs_rise) begin
                    state_next = RECV;
                    cnt_clear  = 1'b1;
                    tmr_clear  = 1'b1;
                end else if (cs_fall) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg       <= IDLE;
            end_seen_reg    <= 1'b0;
            bit_cnt_reg     <= '0;
            err_short_reg   <= 1'b0;
            err_timeout_reg <= 1'b0;
            err_overrun_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            end_seen_reg    <= end_seen_next;
            err_short_reg   <= short_next;
            err_timeout_reg <= timeout_next;
            err_overrun_reg <= overrun_next;
            if (cnt_clear) begin
                bit_cnt_reg <= '0;
            end else if (cnt_inc) begin
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
        end
    end

    // A capture in the same cycle as a consume reloads instead of dropping valid.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else if (capture && !overrun_next) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= rx_data;
        end else if (out_valid_reg && out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign shift_en    = bit_strobe && (state_reg == RECV);
    assign busy        = (state_reg != IDLE);
    assign out_valid   = out_valid_reg;
    assign out_data    = out_data_reg;
    assign err_short   = err_short_reg;
    assign err_timeout = err_timeout_reg;
    assign err_overrun = err_overrun_reg;

endmodule

// File: tb/tb_spi_rx_ctrl.sv
// Directed bench for spi_rx_ctrl: stimulus queues expected events, a monitor
// matches every frame handshake and error pulse against that queue.
module tb_spi_rx_ctrl;

    localparam int DW = 16;
    localparam int DQ = 2;
    localparam int W  = DW * DQ;

    typedef enum {EV_FRAME, EV_SHORT, EV_TIMEOUT, EV_OVERRUN} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [31:0] data;
    } ev_t;

    logic         clk = 1'b0;
    logic         nrst = 1'b0;
    logic         cs_rise = 1'b0, cs_fall = 1'b0, bit_strobe = 1'b0;
    logic [W-1:0] rx_data = '0;
    logic         out_ready = 1'b0;
    logic         shift_en, busy, out_valid;
    logic [W-1:0] out_data;
    logic         err_short, err_timeout, err_overrun;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  shift_cnt = 0;

    spi_rx_ctrl #(.DATA_WIDTH(DW), .DATA_QUANTITY(DQ), .TIMEOUT_CYCLES(8)) dut (
        .clk         (clk),
        .nrst        (nrst),
        .cs_rise     (cs_rise),
        .cs_fall     (cs_fall),
        .bit_strobe  (bit_strobe),
        .rx_data     (rx_data),
        .out_ready   (out_ready),
        .shift_en    (shift_en),
        .busy        (busy),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .err_short   (err_short),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_ev(input ev_kind_t k, input logic [31:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic observe(input ev_kind_t k, input logic [31:0] d);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got %s data %h, expected nothing", k.name(), d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || (k == EV_FRAME && e.data !== d)) begin
                n_fail++;
                $display("FAIL event_match: got %s data %h, expected %s data %h",
                         k.name(), d, e.kind.name(), e.data);
            end else begin
                $display("t=%0t event %s data %h", $time, k.name(), d);
            end
        end
    endtask

    // Outputs are stable mid-cycle; a valid&ready seen here completes on the next edge.
    always @(negedge clk) begin
        if (nrst) begin
            if (shift_en) shift_cnt++;
            if (err_short)   observe(EV_SHORT, 32'h0);
            if (err_timeout) observe(EV_TIMEOUT, 32'h0);
            if (err_overrun) observe(EV_OVERRUN, 32'h0);
            if (out_valid && out_ready) observe(EV_FRAME, out_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // cs_rise, then n strobes 4 clk apart; returns just after the edge sampling the last one.
    task automatic do_frame(input int n, input bit fall_with_last);
        cs_rise = 1'b1;
        tick();
        cs_rise = 1'b0;
        tick();
        for (int i = 0; i < n; i++) begin
            bit_strobe = 1'b1;
            if (i == n - 1 && fall_with_last) cs_fall = 1'b1;
            tick();
            bit_strobe = 1'b0;
            cs_fall    = 1'b0;
            if (i != n - 1) repeat (3) tick();
        end
    endtask

    task automatic end_frame();
        cs_fall = 1'b1;
        tick();
        cs_fall = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_out_valid", 32'(out_valid), 32'h0);
        check("reset_out_data", out_data, 32'h0);
        check("reset_errors", {29'h0, err_short, err_timeout, err_overrun}, 32'h0);
        tick();
        nrst = 1'b1;
        tick();

        // 1: nominal frame and latency
        out_ready = 1'b1;
        rx_data   = 32'hA5A5_3C3C;
        shift_cnt = 0;
        push_ev(EV_FRAME, 32'hA5A5_3C3C);
        do_frame(16, 1'b0);
        check("t1_valid_early", 32'(out_valid), 32'h0);
        tick();
        check("t1_valid", 32'(out_valid), 32'h1);
        check("t1_data", out_data, 32'hA5A5_3C3C);
        tick();
        check("t1_consumed", 32'(out_valid), 32'h0);
        end_frame();
        check("t1_shift_cnt", shift_cnt, 32'd16);
        check("t1_idle", 32'(busy), 32'h0);

        // 2: short frame
        do_frame(9, 1'b0);
        push_ev(EV_SHORT, 32'h0);
        cs_fall = 1'b1;
        tick();
        cs_fall = 1'b0;
        check("t2_err_short", 32'(err_short), 32'h1);
        check("t2_busy", 32'(busy), 32'h0);
        tick();
        check("t2_err_short_width", 32'(err_short), 32'h0);
        check("t2_valid", 32'(out_valid), 32'h0);

        // 3: stalled clock, timeout exactly 8 clk after the last strobe
        do_frame(3, 1'b0);
        push_ev(EV_TIMEOUT, 32'h0);
        repeat (7) tick();
        check("t3_no_early_timeout", 32'(err_timeout), 32'h0);
        check("t3_busy_before", 32'(busy), 32'h1);
        tick();
        check("t3_err_timeout", 32'(err_timeout), 32'h1);
        check("t3_busy_after", 32'(busy), 32'h0);
        rx_data = 32'h0F0F_F0F0;
        push_ev(EV_FRAME, 32'h0F0F_F0F0);
        do_frame(16, 1'b0);
        repeat (2) tick();
        end_frame();

        // 4: overrun keeps the first frame
        out_ready = 1'b0;
        rx_data   = 32'h1111_1111;
        do_frame(16, 1'b0);
        end_frame();
        check("t4_first_valid", 32'(out_valid), 32'h1);
        rx_data = 32'h2222_2222;
        push_ev(EV_OVERRUN, 32'h0);
        do_frame(16, 1'b0);
        tick();
        check("t4_err_overrun", 32'(err_overrun), 32'h1);
        check("t4_data_kept", out_data, 32'h1111_1111);
        repeat (3) tick();
        check("t4_data_stable", out_data, 32'h1111_1111);
        check("t4_valid_stable", 32'(out_valid), 32'h1);
        end_frame();
        push_ev(EV_FRAME, 32'h1111_1111);
        out_ready = 1'b1;
        tick();
        check("t4_drained", 32'(out_valid), 32'h0);

        // 5a: cs_fall together with the last strobe
        rx_data = 32'h5A5A_C3C3;
        push_ev(EV_FRAME, 32'h5A5A_C3C3);
        do_frame(16, 1'b1);
        check("t5a_capture_busy", 32'(busy), 32'h1);
        tick();
        check("t5a_idle", 32'(busy), 32'h0);
        check("t5a_valid", 32'(out_valid), 32'h1);
        tick();

        // 5b: extra strobes after the last bit do not shift
        rx_data   = 32'h7654_3210;
        shift_cnt = 0;
        push_ev(EV_FRAME, 32'h7654_3210);
        do_frame(16, 1'b0);
        repeat (2) tick();
        for (int i = 0; i < 3; i++) begin
            bit_strobe = 1'b1;
            tick();
            bit_strobe = 1'b0;
            tick();
        end
        check("t5b_shift_cnt", shift_cnt, 32'd16);
        check("t5b_wait_busy", 32'(busy), 32'h1);
        end_frame();

        // 6: asynchronous reset mid-frame, with a frame still pending
        out_ready = 1'b0;
        rx_data   = 32'h3333_3333;
        do_frame(16, 1'b0);
        end_frame();
        do_frame(7, 1'b0);
        #3;
        nrst = 1'b0;
        #1;
        check("t6_valid_cleared", 32'(out_valid), 32'h0);
        check("t6_data_cleared", out_data, 32'h0);
        check("t6_busy_cleared", 32'(busy), 32'h0);
        tick();
        nrst      = 1'b1;
        out_ready = 1'b1;
        rx_data   = 32'hDEAD_BEEF;
        push_ev(EV_FRAME, 32'hDEAD_BEEF);
        do_frame(16, 1'b0);
        tick();
        check("t6_frame_data", out_data, 32'hDEAD_BEEF);
        tick();
        end_frame();

        repeat (4) tick();
        check("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
